// File: rtl/quad_pkg.sv
// Shared types and the phase-transition decoder for the quadrature counter.
package quad_pkg;

    typedef enum logic [1:0] {
        MODE_X1 = 2'b00,
        MODE_X2 = 2'b01,
        MODE_X4 = 2'b10
    } mode_e;

    typedef enum logic {
        INIT,
        RUN
    } fsm_e;

    typedef enum logic [1:0] {
        NONE,
        FWD,
        REV,
        ILLEGAL
    } move_e;

    // Position in the forward cycle 00->01->11->10 is the Gray-to-binary value of {B,A}.
    function automatic logic [1:0] phase_index(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    function automatic move_e decode_move(input logic [1:0] p, input logic [1:0] n);
        logic [1:0] pi;
        logic [1:0] ni;
        pi = phase_index(p);
        ni = phase_index(n);
        if (p == n) begin
            return NONE;
        end
        if ((p ^ n) == 2'b11) begin
            return ILLEGAL;
        end
        if (ni == pi + 2'd1) begin
            return FWD;
        end
        return REV;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Per-bit synchroniser and run-length glitch filter for the encoder channels.
// level_next is the accepted value that will be registered on the coming edge.
module quad_input_filter #(
    parameter int WIDTH       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    input  logic             load,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] level_next
);

    localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0][CW-1:0]          cnt_q;
    logic [WIDTH-1:0][CW-1:0]          cnt_next;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // The counter never needs to hold FILT_LEN itself: the edge that would reach it
    // accepts the new level, after which the channel matches again and the count restarts.
    always_comb begin
        level_next = level;
        cnt_next   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (load) begin
                level_next[i] = sync[i];
            end else if (sync[i] != level[i]) begin
                if (cnt_q[i] == LAST) begin
                    level_next[i] = sync[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
            cnt_q <= '0;
        end else begin
            level <= level_next;
            cnt_q <= cnt_next;
        end
    end

endmodule

// File: rtl/quadrature_counter.sv
// Quadrature decoder and position counter with x1/x2/x4 resolution,
// direction/step outputs and a sticky illegal-transition flag.
module quadrature_counter
    import quad_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       enc,
    input  logic [1:0]       mode,
    input  logic             clear,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    localparam int SW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
    localparam logic [SW-1:0] STABLE_LAST = SW'(FILT_LEN - 1);

    logic [1:0]    sync;
    logic [1:0]    level;
    logic [1:0]    level_next;
    logic [1:0]    sync_prev;
    logic [SW-1:0] stable_cnt;
    fsm_e          state;
    mode_e         mode_sel;
    move_e         move;
    logic          load;
    logic          do_count;
    logic          set_err;

    quad_input_filter #(
        .WIDTH       (2),
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filter (
        .clk        (clk),
        .reset      (reset),
        .raw        (enc),
        .load       (load),
        .sync       (sync),
        .level      (level),
        .level_next (level_next)
    );

    always_comb begin
        case (mode)
            2'b00:   mode_sel = MODE_X1;
            2'b01:   mode_sel = MODE_X2;
            default: mode_sel = MODE_X4;
        endcase
    end

    // Moves are decoded against the level being accepted this edge, so count
    // lands on the same edge as the filter's decision.
    always_comb begin
        load     = (state == INIT) && (sync == sync_prev) && (stable_cnt == STABLE_LAST);
        move     = (state == RUN) ? decode_move(level, level_next) : NONE;
        set_err  = (move == ILLEGAL);
        do_count = 1'b0;
        if (move == FWD || move == REV) begin
            case (mode_sel)
                MODE_X1: do_count = (level == 2'b00 && level_next == 2'b01) ||
                                    (level == 2'b01 && level_next == 2'b00);
                MODE_X2: do_count = (level[0] != level_next[0]);
                default: do_count = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            stable_cnt <= '0;
            sync_prev  <= '0;
            count      <= '0;
            dir        <= 1'b0;
            step       <= 1'b0;
            err        <= 1'b0;
        end else begin
            sync_prev <= sync;
            step      <= 1'b0;

            case (state)
                INIT: begin
                    if (load) begin
                        state      <= RUN;
                        stable_cnt <= '0;
                    end else if (sync == sync_prev) begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end else begin
                        stable_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase

            if (move == FWD || move == REV) begin
                dir <= (move == FWD);
            end

            if (clear) begin
                count <= '0;
            end else if (do_count) begin
                count <= (move == FWD) ? count + 1'b1 : count - 1'b1;
                step  <= 1'b1;
            end

            // A fresh illegal move outranks a simultaneous clear request.
            if (set_err) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
